pipeline_id_ex_hs: RTL
======================

PIPELINE_ID_EX_HS -- requirements
Module: pipeline_id_ex_hs

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of RD1/RD2/PC/PCP4/ImmExt.
REQ-002 Parameter REG_AW, default 5, register-index width of Rs1/Rs2/Rd.
REQ-003 Ports: clk  in  1  single clock; all state updates on posedge clk.
REQ-004 Ports: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: flush  in  1  kill all held and incoming entries this cycle.
REQ-006 Ports: valid_D  in  1 / ready_D  out  1  upstream (ID) handshake.
REQ-007 Ports: RD1_D, RD2_D, PC_D, PCP4_D, ImmExt_D  in  WIDTH each / Rs1_D, Rs2_D, Rd_D  in  REG_AW each / ctrl_D  in  ctrl_t  ID payload.
REQ-008 Ports: valid_E  out  1 / ready_E  in  1  downstream (EX) handshake.
REQ-009 Ports: RD1_E..Rd_E, ctrl_E  out, same widths as the _D ports  EX payload.
REQ-010 Ports (PIPE_PERF_CNT_EN only): stall_cnt, bubble_cnt  out  32 each  performance counters.

Function
REQ-011 Two storage slots: main (drives _E outputs) and skid (one-entry overflow); full throughput of 1 entry/cycle when ready_E=1.
REQ-012 Transfer in on valid_D&&ready_D; transfer out on valid_E&&ready_E.
REQ-013 ready_D is a registered output, equal to !skid_valid; no combinational path from ready_E to ready_D.
REQ-014 Main empty or draining: incoming entry loads main; latency 1 cycle D->E.
REQ-015 Main full and not draining, skid empty: incoming entry loads skid; ready_D goes 0 next cycle.
REQ-016 Main draining while skid full: skid moves to main in that cycle; ready_D returns to 1 next cycle.
REQ-017 Main held (valid_E=1, ready_E=0): all _E outputs stable, bit-for-bit.
REQ-018 valid_E=0: ctrl_E.RegWrite=0, ctrl_E.MemWrite=0, ctrl_E.MemRead=0, ctrl_E.PCsrc=PC_NEXT regardless of stored contents; data _E fields don't-care.
REQ-019 flush=1: next cycle main_valid=0, skid_valid=0, ready_D=1; an entry presented the same cycle is dropped; flush overrides every simultaneous transfer.
REQ-020 Non-ctrl payload fields need not be cleared on flush or reset.
REQ-021 Ordering preserved: entries exit in arrival order; no entry duplicated or lost except by flush.

Reset
REQ-022 rst=1 at posedge: main_valid=0, skid_valid=0, ready_D=1, valid_E=0, ctrl_E per REQ-018, counters 0.
REQ-023 rst has priority over flush and all handshakes; entries in flight at reset are discarded.
REQ-024 First transfer accepted in the cycle after rst deasserts.

Configuration
REQ-025 Macro PIPE_PERF_CNT_EN defined: stall_cnt increments each cycle valid_E&&!ready_E; bubble_cnt increments each cycle !valid_E&&!rst; both wrap 0xFFFFFFFF->0; flush does not clear them.
REQ-026 Macro PIPE_PERF_CNT_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-027 Shared package holds ctrl_t (packed: RegWrite 1, ResultSrc 2, MemWrite 1, MemRead 1, AddrMode 3, PCsrc 3, ALUctrl 4, ALUsrc 1), constant PC_NEXT, and constant CTRL_NOP (a killed ctrl_t value).
REQ-028 One sub-module, pipeline_skid_slot (valid bit plus payload register, load/clear inputs), instantiated twice for main and skid.

Verification
REQ-029 Reset: rst=1 for 2 cycles with valid_D=1 -> valid_E=0, ready_D=1, ctrl_E.RegWrite=0, PCsrc=PC_NEXT.
REQ-030 Streaming: 8 back-to-back entries PC_D=0x00,0x04..0x1C, ready_E=1 -> PC_E sequence identical, each 1 cycle late, no gaps.
REQ-031 Backpressure: ready_E=0 for 3 cycles mid-stream -> ready_D drops after 2nd held entry, _E stable; on ready_E=1 order 0x08,0x0C,0x10 with no loss.
REQ-032 Flush with skid full plus valid_D=1 (MemWrite_D=1) -> next cycle valid_E=0, MemWrite_E=0, ready_D=1; flushed entries never appear.
REQ-033 Simultaneous flush and rst -> reset state (REQ-022); counters 0.
REQ-034 PIPE_PERF_CNT_EN: 5 cycles valid_E=1, ready_E=0 then 3 idle cycles -> stall_cnt=5, bubble_cnt=3.

Source files
------------

// File: rtl/pipeline_id_ex_hs_pkg.sv
// Shared types for the ID/EX handshake pipeline register: control bundle,
// the PC_NEXT select value and the killed (bubble) control word.
package pipeline_id_ex_hs_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       MemRead;
        logic [2:0] AddrMode;
        logic [2:0] PCsrc;
        logic [3:0] ALUctrl;
        logic       ALUsrc;
    } ctrl_t;

    localparam logic [2:0] PC_NEXT = 3'b000;

    // Bubble: no architectural side effects, sequential PC.
    localparam ctrl_t CTRL_NOP = '{
        RegWrite:  1'b0,
        ResultSrc: 2'b00,
        MemWrite:  1'b0,
        MemRead:   1'b0,
        AddrMode:  3'b000,
        PCsrc:     PC_NEXT,
        ALUctrl:   4'b0000,
        ALUsrc:    1'b0
    };

endpackage

// File: rtl/pipeline_id_ex_hs_skid_slot.sv
// One storage slot: valid bit plus payload register. Payload is not reset;
// only the valid bit carries architectural meaning.
module pipeline_skid_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kill_i,
    input  logic         load_i,
    input  logic         drop_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] pl_q, pl_d;

    // kill beats load so a flush drops an entry arriving the same cycle
    always_comb begin
        vld_d = vld_q;
        pl_d  = pl_q;
        if (load_i) pl_d = d_i;
        if (kill_i)      vld_d = 1'b0;
        else if (load_i) vld_d = 1'b1;
        else if (drop_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        pl_q <= pl_d;
    end

    assign vld_o = vld_q;
    assign q_o   = pl_q;

endmodule

// File: rtl/pipeline_id_ex_hs.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid
// buffer so ready_D is registered. Optional counters: PIPE_PERF_CNT_EN.
module pipeline_id_ex_hs
    import pipeline_id_ex_hs_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_D,
    output logic              ready_D,
    input  logic [WIDTH-1:0]  RD1_D,
    input  logic [WIDTH-1:0]  RD2_D,
    input  logic [WIDTH-1:0]  PC_D,
    input  logic [WIDTH-1:0]  PCP4_D,
    input  logic [WIDTH-1:0]  ImmExt_D,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rd_D,
    input  ctrl_t             ctrl_D,
    output logic              valid_E,
    input  logic              ready_E,
    output logic [WIDTH-1:0]  RD1_E,
    output logic [WIDTH-1:0]  RD2_E,
    output logic [WIDTH-1:0]  PC_E,
    output logic [WIDTH-1:0]  PCP4_E,
    output logic [WIDTH-1:0]  ImmExt_E,
    output logic [REG_AW-1:0] Rs1_E,
    output logic [REG_AW-1:0] Rs2_E,
    output logic [REG_AW-1:0] Rd_E,
    output ctrl_t             ctrl_E
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam int PW = 5*WIDTH + 3*REG_AW + $bits(ctrl_t);

    logic          main_v, skid_v;
    logic [PW-1:0] in_pl, main_pl, skid_pl, main_src;
    logic          in_xfer, out_xfer, drain;
    logic          main_load, main_drop, skid_load, skid_drop;
    ctrl_t         ctrl_st;

    assign in_pl = {RD1_D, RD2_D, PC_D, PCP4_D, ImmExt_D, Rs1_D, Rs2_D, Rd_D, ctrl_D};

    assign ready_D  = !skid_v;
    assign in_xfer  = valid_D && ready_D;
    assign out_xfer = main_v && ready_E;
    assign drain    = !main_v || ready_E;

    // A full skid means ready_D was low, so no new entry can race it into main.
    assign main_load = skid_v ? out_xfer : (in_xfer && drain);
    assign main_src  = skid_v ? skid_pl  : in_pl;
    assign main_drop = out_xfer;
    assign skid_load = !skid_v && in_xfer && !drain;
    assign skid_drop = skid_v && out_xfer;

    pipeline_skid_slot #(.W(PW)) u_main (
        .clk    (clk),
        .rst    (rst),
        .kill_i (flush),
        .load_i (main_load),
        .drop_i (main_drop),
        .d_i    (main_src),
        .vld_o  (main_v),
        .q_o    (main_pl)
    );

    pipeline_skid_slot #(.W(PW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .kill_i (flush),
        .load_i (skid_load),
        .drop_i (skid_drop),
        .d_i    (in_pl),
        .vld_o  (skid_v),
        .q_o    (skid_pl)
    );

    assign {RD1_E, RD2_E, PC_E, PCP4_E, ImmExt_E, Rs1_E, Rs2_E, Rd_E, ctrl_st} = main_pl;
    assign valid_E = main_v;
    assign ctrl_E  = main_v ? ctrl_st : CTRL_NOP;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, stall_d, bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_v && !ready_E) stall_d  = stall_q + 32'd1;
        if (!main_v)            bubble_d = bubble_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule
